// File: rtl/dac_stream_channel.sv
// DAC channel datapath: raw/live/stream source mux, stream FIFO + lane unpacker,
// gain/offset/clamp pipeline and optional window statistics (DAC_STREAM_CHANNEL_STATS_EN).
module dac_stream_channel #(
  parameter int WIDTH      = 8,
  parameter int NUM_SRC    = 6,
  parameter int FIFO_DEPTH = 16,
  parameter int GAIN_W     = 16,
  parameter int GAIN_RADIX = 8,
  localparam int SEL_W     = $clog2(NUM_SRC + 2)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SEL_W-1:0]         sel,
  input  logic [WIDTH-1:0]         raw,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic                     sample_en,
  input  logic [31:0]              s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [GAIN_W-1:0]        gain,
  input  logic [WIDTH-1:0]         offset,
  output logic [WIDTH-1:0]         dac_out,
  output logic                     dac_valid,
  output logic [15:0]              underrun_cnt,
  input  logic                     stat_clear,
  input  logic [31:0]              stat_window,
  output logic [WIDTH-1:0]         stat_min,
  output logic [WIDTH-1:0]         stat_max,
  output logic                     stat_done
);

  localparam int LANES  = 32 / WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int PW     = WIDTH + GAIN_W;

  localparam logic signed [WIDTH-1:0] FS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] FS_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [PW:0]      SAT_HI = (PW+1)'(FS_MAX);
  localparam logic signed [PW:0]      SAT_LO = (PW+1)'(FS_MIN);
  localparam logic [SEL_W-1:0]        STRM_CODE = SEL_W'(NUM_SRC + 1);

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW:0] v);
    if (v > SAT_HI)      sat = SAT_HI[WIDTH-1:0];
    else if (v < SAT_LO) sat = SAT_LO[WIDTH-1:0];
    else                 sat = v[WIDTH-1:0];
  endfunction

  // Stream FIFO; s_ready is forced low while reset is held.
  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   fcnt_q;
  logic             full, empty, wr_en, rd_en;
  logic [31:0]      head;

  assign full    = (fcnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (fcnt_q == '0);
  assign wr_en   = s_valid & ~full;
  assign s_ready = ~full & ~reset;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   fcnt_q <= fcnt_q + (PTR_W+1)'(1);
        2'b01:   fcnt_q <= fcnt_q - (PTR_W+1)'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  // Unpacker: an empty unpacker serves lane 0 straight from the FIFO head.
  logic              have_q, have_d;
  logic [LANE_W-1:0] lane_q, lane_d, cur_lane;
  logic [31:0]       word_q, word_d, cur_word, word_sh;
  logic [WIDTH-1:0]  strm_q, strm_d, lane_val, strm_val;
  logic [15:0]       under_q, under_d;
  logic              cons, avail, last;

  assign cons     = sample_en & (sel == STRM_CODE);
  assign avail    = have_q | ~empty;
  assign last     = (lane_q == LANE_W'(LANES - 1));
  assign cur_lane = have_q ? lane_q : '0;
  assign cur_word = have_q ? word_q : head;
  assign word_sh  = cur_word >> (32'(cur_lane) * WIDTH);
  assign lane_val = word_sh[WIDTH-1:0];
  assign strm_val = avail ? lane_val : strm_q;

  always_comb begin
    have_d  = have_q;
    lane_d  = lane_q;
    word_d  = word_q;
    strm_d  = strm_q;
    under_d = under_q;
    rd_en   = 1'b0;
    if (cons) begin
      if (avail)                     strm_d  = lane_val;
      else if (under_q != 16'hFFFF)  under_d = under_q + 16'd1;
      if (have_q) begin
        if (last) begin
          if (!empty) begin
            rd_en  = 1'b1;
            word_d = head;
            lane_d = '0;
            have_d = 1'b1;
          end else begin
            have_d = 1'b0;
          end
        end else begin
          lane_d = lane_q + LANE_W'(1);
        end
      end else if (!empty) begin
        rd_en  = 1'b1;
        word_d = head;
        if (LANES == 1) begin
          have_d = 1'b0;
        end else begin
          have_d = 1'b1;
          lane_d = LANE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      have_q  <= 1'b0;
      lane_q  <= '0;
      strm_q  <= '0;
      under_q <= '0;
    end else begin
      have_q  <= have_d;
      lane_q  <= lane_d;
      strm_q  <= strm_d;
      under_q <= under_d;
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign underrun_cnt = under_q;

  logic [WIDTH-1:0] mux_val;

  always_comb begin
    mux_val = '0;
    if (sel == '0) mux_val = raw;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k + 1)) mux_val = src_data[k*WIDTH +: WIDTH];
    end
    if (sel == STRM_CODE) mux_val = strm_val;
  end

  logic                     vld_p1_q, vld_p2_q, dac_valid_q;
  logic signed [WIDTH-1:0]  m_p1_q;
  logic signed [PW:0]       sum_p2_q;
  logic signed [WIDTH-1:0]  dac_out_q;
  logic signed [GAIN_W-1:0] gain_s;
  logic signed [WIDTH-1:0]  off_s;
  logic signed [PW-1:0]     prod_p1, shr_p1;
  logic signed [PW:0]       sum_p1;

  assign gain_s  = gain;
  assign off_s   = offset;
  assign prod_p1 = PW'(m_p1_q) * PW'(gain_s);
  assign shr_p1  = prod_p1 >>> GAIN_RADIX;
  assign sum_p1  = (PW+1)'(shr_p1) + (PW+1)'(off_s);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      dac_valid_q <= 1'b0;
      dac_out_q   <= '0;
    end else begin
      vld_p1_q    <= sample_en;
      vld_p2_q    <= vld_p1_q;
      dac_valid_q <= vld_p2_q;
      if (vld_p2_q) dac_out_q <= sat(sum_p2_q);
    end
  end

  always_ff @(posedge clk) begin
    // stage 1: capture selected sample
    if (sample_en) m_p1_q <= mux_val;
    // stage 2: scaled product plus offset
    sum_p2_q <= sum_p1;
  end

  assign dac_out   = dac_out_q;
  assign dac_valid = dac_valid_q;

`ifdef DAC_STREAM_CHANNEL_STATS_EN
  logic [31:0]             st_cnt_q, st_cnt_nx;
  logic signed [WIDTH-1:0] run_min_q, run_max_q, run_min_nx, run_max_nx;
  logic signed [WIDTH-1:0] st_min_q, st_max_q;
  logic                    st_done_q;

  assign st_cnt_nx  = st_cnt_q + 32'd1;
  assign run_min_nx = (dac_out_q < run_min_q) ? dac_out_q : run_min_q;
  assign run_max_nx = (dac_out_q > run_max_q) ? dac_out_q : run_max_q;

  // A window shrunk below the running count closes on the next sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_cnt_q  <= '0;
      run_min_q <= FS_MAX;
      run_max_q <= FS_MIN;
      st_min_q  <= '0;
      st_max_q  <= '0;
      st_done_q <= 1'b0;
    end else begin
      st_done_q <= 1'b0;
      if (stat_clear) begin
        st_cnt_q  <= '0;
        run_min_q <= FS_MAX;
        run_max_q <= FS_MIN;
      end else if (dac_valid_q && stat_window != '0) begin
        if (st_cnt_nx >= stat_window) begin
          st_min_q  <= run_min_nx;
          st_max_q  <= run_max_nx;
          st_done_q <= 1'b1;
          st_cnt_q  <= '0;
          run_min_q <= FS_MAX;
          run_max_q <= FS_MIN;
        end else begin
          st_cnt_q  <= st_cnt_nx;
          run_min_q <= run_min_nx;
          run_max_q <= run_max_nx;
        end
      end
    end
  end

  assign stat_min  = st_min_q;
  assign stat_max  = st_max_q;
  assign stat_done = st_done_q;
`else
  logic stat_unused;
  assign stat_unused = ^{stat_clear, stat_window};
  assign stat_min    = '0;
  assign stat_max    = '0;
  assign stat_done   = 1'b0;
`endif

endmodule

// File: tb/tb_dac_stream_channel.sv
// Directed bench for dac_stream_channel (WIDTH=8, NUM_SRC=6, FIFO_DEPTH=16).
module tb_dac_stream_channel;

`ifdef DAC_STREAM_CHANNEL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sel;
  logic [7:0]  raw;
  logic [47:0] src_data;
  logic        sample_en;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] gain;
  logic [7:0]  offset;
  logic [7:0]  dac_out;
  logic        dac_valid;
  logic [15:0] underrun_cnt;
  logic        stat_clear;
  logic [31:0] stat_window;
  logic [7:0]  stat_min;
  logic [7:0]  stat_max;
  logic        stat_done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int acc;

  dac_stream_channel dut (
    .clk(clk), .reset(rst), .sel(sel), .raw(raw), .src_data(src_data),
    .sample_en(sample_en), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .gain(gain), .offset(offset), .dac_out(dac_out), .dac_valid(dac_valid),
    .underrun_cnt(underrun_cnt), .stat_clear(stat_clear), .stat_window(stat_window),
    .stat_min(stat_min), .stat_max(stat_max), .stat_done(stat_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (stat_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input string tag, input logic [7:0] exp);
    sample_en = 1'b1;
    tick;
    sample_en = 1'b0;
    tick;
    tick;
    chk({tag, "_vld"}, 32'(dac_valid), 32'd1);
    chk(tag, 32'(dac_out), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; sel = '0; raw = '0; src_data = '0; sample_en = 1'b0;
    s_data = '0; s_valid = 1'b0; gain = 16'h0100; offset = '0;
    stat_clear = 1'b0; stat_window = '0;
    tick;
    tick;
    chk("rst_sready", 32'(s_ready), 32'd0);
    chk("rst_dac", 32'(dac_out), 32'd0);
    chk("rst_vld", 32'(dac_valid), 32'd0);
    chk("rst_under", 32'(underrun_cnt), 32'd0);
    chk("rst_smin", 32'(stat_min), 32'd0);
    chk("rst_smax", 32'(stat_max), 32'd0);
    chk("rst_sdone", 32'(stat_done), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_sready", 32'(s_ready), 32'd1);
    tick;

    // Latency: pulse in cycle n -> dac_valid in n+3, single cycle, value held.
    raw = 8'h10;
    sample_en = 1'b1;
    tick;
    sample_en = 1'b0;
    chk("lat1_vld", 32'(dac_valid), 32'd0);
    tick;
    chk("lat2_vld", 32'(dac_valid), 32'd0);
    tick;
    chk("lat3_vld", 32'(dac_valid), 32'd1);
    chk("lat3_out", 32'(dac_out), 32'h10);
    tick;
    chk("lat4_vld", 32'(dac_valid), 32'd0);
    chk("lat4_hold", 32'(dac_out), 32'h10);

    // Gain, clamping and floor rounding on live source lanes.
    sel = 3'd1;
    gain = 16'h0200;
    src_data = {40'd0, 8'd100};
    sample("clamp_hi", 8'h7F);
    src_data = {40'd0, 8'h9C};
    sample("clamp_lo", 8'h80);
    gain = 16'h0080; offset = 8'hFD;
    src_data = {40'd0, 8'd7};
    sample("floor_pos", 8'h00);
    offset = 8'h00;
    src_data = {40'd0, 8'hF9};
    sample("floor_neg", 8'hFC);
    gain = 16'h0100;
    sel = 3'd6;
    src_data = {8'h33, 40'd0};
    sample("lane5", 8'h33);

    // Stream unpack LSB first, then two underruns holding the last sample.
    s_data = 32'h44332211;
    s_valid = 1'b1;
    tick;
    s_valid = 1'b0;
    sel = 3'd7;
    sample("strm0", 8'h11);
    sample("strm1", 8'h22);
    sample("strm2", 8'h33);
    sample("strm3", 8'h44);
    sample("strm4", 8'h44);
    sample("strm5", 8'h44);
    chk("strm_under", 32'(underrun_cnt), 32'd2);

    // Fill with stream deselected, then drain four lanes back-to-back.
    sel = 3'd0;
    s_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      s_data = 32'h04030201 + 32'(i) * 32'h01010101;
      if (s_ready) acc++;
      tick;
    end
    chk("fill_acc", 32'(acc), 32'd16);
    chk("fill_sready", 32'(s_ready), 32'd0);
    sel = 3'd7;
    sample_en = 1'b1;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      if (s_ready) acc++;
      tick;
    end
    sample_en = 1'b0;
    s_valid = 1'b0;
    chk("drain_acc", 32'(acc), 32'd1);
    chk("drain_sready", 32'(s_ready), 32'd1);
    tick;
    tick;
    chk("drain_vld", 32'(dac_valid), 32'd1);
    chk("drain_out", 32'(dac_out), 32'h04);
    chk("drain_under", 32'(underrun_cnt), 32'd2);

    // Window statistics on raw samples.
    sel = 3'd0;
    stat_window = 32'd4;
    raw = 8'd5;   sample("st_a", 8'd5);
    raw = 8'hFE;  sample("st_b", 8'hFE);
    raw = 8'd9;   sample("st_c", 8'd9);
    raw = 8'd1;   sample("st_d", 8'd1);
    tick;
    chk("win1_done", 32'(stat_done), 32'(STATS));
    chk("win1_min", 32'(stat_min), STATS ? 32'hFE : 32'h0);
    chk("win1_max", 32'(stat_max), STATS ? 32'h09 : 32'h0);
    tick;
    chk("win1_pulse", 32'(stat_done), 32'd0);
    chk("win1_cnt", 32'(done_cnt), STATS ? 32'd1 : 32'd0);
    raw = 8'd3;   sample("st_e", 8'd3);
    raw = 8'd4;   sample("st_f", 8'd4);
    stat_clear = 1'b1;
    tick;
    stat_clear = 1'b0;
    chk("clr_min", 32'(stat_min), STATS ? 32'hFE : 32'h0);
    chk("clr_max", 32'(stat_max), STATS ? 32'h09 : 32'h0);
    raw = 8'd7;   sample("st_g", 8'd7);
    raw = 8'hFB;  sample("st_h", 8'hFB);
    raw = 8'd6;   sample("st_i", 8'd6);
    tick;
    tick;
    chk("clr_nodone", 32'(done_cnt), STATS ? 32'd1 : 32'd0);
    raw = 8'd2;   sample("st_j", 8'd2);
    tick;
    chk("win2_done", 32'(stat_done), 32'(STATS));
    chk("win2_min", 32'(stat_min), STATS ? 32'hFB : 32'h0);
    chk("win2_max", 32'(stat_max), STATS ? 32'h07 : 32'h0);

    // Asynchronous reset with words still queued.
    rst = 1'b1;
    #1;
    chk("arst_dac", 32'(dac_out), 32'd0);
    chk("arst_under", 32'(underrun_cnt), 32'd0);
    chk("arst_sready", 32'(s_ready), 32'd0);
    chk("arst_smin", 32'(stat_min), 32'd0);
    chk("arst_smax", 32'(stat_max), 32'd0);
    tick;
    rst = 1'b0;
    #1;
    chk("arel_sready", 32'(s_ready), 32'd1);
    sel = 3'd7;
    sample("post_rst", 8'h00);
    chk("post_rst_under", 32'(underrun_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac_stream_channel.md
Name: dac_stream_channel

Overview:
Parametrised DAC channel datapath with configurable sample width and source count. It selects one of a raw register value, NUM_SRC live sources, or a backpressured 32-bit stream. Stream words pass through an internal FIFO and are unpacked into samples. The selected sample goes through gain/offset/clamp and per-window min/max statistics, and drives the DAC pins at a rate set by sample_en.

Parameters:
- WIDTH, 8, sample width in bits; legal values 8, 16, 32 (LANES = 32/WIDTH).
- NUM_SRC, 6, number of live source inputs.
- FIFO_DEPTH, 16, stream FIFO depth in 32-bit words; power of 2, at least 2.
- GAIN_W, 16, signed gain width.
- GAIN_RADIX, 8, fractional bits of gain (gain 1.0 = 2^GAIN_RADIX).
- SEL_W, derived as $clog2(NUM_SRC+2), width of sel.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- sel  in  SEL_W  source select: 0 = raw, 1..NUM_SRC = src_data lane sel-1, NUM_SRC+1 = stream; other codes select zero.
- raw  in  WIDTH  register-driven constant sample.
- src_data  in  NUM_SRC*WIDTH  live sources; lane k is bits [k*WIDTH +: WIDTH].
- sample_en  in  1  sample-rate strobe.
- s_data  in  32  stream word.
- s_valid  in  1  stream word valid.
- s_ready  out  1  stream word accepted when s_valid and s_ready are both high.
- gain  in  GAIN_W  signed gain.
- offset  in  WIDTH  signed offset.
- dac_out  out  WIDTH  signed output sample.
- dac_valid  out  1  one-cycle pulse when dac_out updates.
- underrun_cnt  out  16  saturating stream underrun count.
- stat_clear  in  1  synchronous statistics clear.
- stat_window  in  32  samples per statistics window; 0 disables statistics.
- stat_min  out  WIDTH  minimum of the last completed window.
- stat_max  out  WIDTH  maximum of the last completed window.
- stat_done  out  1  one-cycle pulse when a window completes.

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO empty, unpacker empty, pipeline valids cleared.
  - dac_out = 0, dac_valid = 0, underrun_cnt = 0, stat_min = 0, stat_max = 0, stat_done = 0.
  - s_ready = 0 while reset is asserted; 1 on the first cycle after release.
- FIFO:
  - s_ready = !full.
  - A write is never accepted when full, even if a read occurs in the same cycle.
  - Read and write in the same cycle when not full: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Unpacker:
  - Holds one word plus a lane index; lanes are consumed LSB first.
  - Advances only when sample_en is high and sel = NUM_SRC+1.
  - After the last lane is consumed, the next word is loaded from the FIFO in the same cycle if one is available.
  - Consume with no word available = underrun: stream sample holds its previous value (0 after reset); underrun_cnt increments, saturating at 0xFFFF.
  - Switching sel away from the stream freezes unpacker state; it resumes at the same lane when reselected.
  - When the stream is not selected, the FIFO fills and then backpressures.
- Pipeline (advances every clock; valid follows sample_en):
  - Stage 1, on sample_en: capture the mux output.
  - Stage 2: p = m * gain as a full-precision signed product, arithmetic right shift by GAIN_RADIX (floor), plus sign-extended offset.
  - Stage 3: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and register into dac_out.
  - sample_en high in cycle n gives dac_valid high in cycle n+3. Back-to-back sample_en is supported.
  - dac_out holds its value between valid pulses.
- Statistics:
  - Updated on each dac_valid: running min and max, plus count.
  - When count reaches stat_window: running values go to stat_min/stat_max, stat_done pulses, and the running state restarts with the next sample.
  - Running state initial values: min = +full-scale, max = -full-scale.
  - stat_clear restarts running state and count; stat_min/stat_max are unchanged. stat_clear wins over a simultaneous window completion (no stat_done).
  - Changing stat_window mid-window takes effect immediately; if count is already at or above the new value, the window completes on the next dac_valid.

Optional Feature:
- Macro: DAC_STREAM_CHANNEL_STATS_EN.
- Defined: statistics logic is present as described above.
- Undefined: statistics logic is removed; stat_min, stat_max and stat_done are tied to 0, and stat_clear and stat_window are ignored. All other behaviour is unchanged.

Test Plan:
- WIDTH=8, sel=0, raw=0x10, gain=0x0100, offset=0, one sample_en pulse -> dac_valid exactly 3 cycles later, dac_out=0x10.
- sel=1, src_data lane 0 = 100, gain=0x0200 -> dac_out=127 (clamped). Lane 0 = -100 -> dac_out=-128. gain=0x0080, offset=-3, lane 0 = 7 -> dac_out=0 (floor(3.5)=3, then 3-3).
- sel=stream, write word 0x44332211, then 6 sample_en pulses -> outputs 0x11, 0x22, 0x33, 0x44, then 0x44 twice; underrun_cnt=2.
- sel=raw, write continuously with FIFO_DEPTH=16 -> exactly 16 words accepted, s_ready=0. Switch to stream, pulse sample_en 4 times -> s_ready=1 and exactly one additional word accepted.
- stat_window=4, samples 5, -2, 9, 1 -> stat_min=-2, stat_max=9, stat_done pulses once. Assert stat_clear after 2 samples of the next window -> no stat_done until 4 more samples.
- Assert reset mid-stream with FIFO half full -> all outputs 0 immediately and FIFO empty. After release, the first stream sample_en counts as an underrun (underrun_cnt=1).
